cut_gen: RTL
============

CUT_GEN -- requirements
Module: cut_gen

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 5, width of read_a and the address down-counter (>=3).
- TEST_W, 2, width of test_in/test_out (>=2).
- LOAD_VAL, 24, counter value loaded on clear.
- TERM_VAL, 25, counter terminal value that ends STZ and toggles lclk.
- CONF_DEPTH, 2, consecutive compare matches that raise conflict (>=1).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s  in  1  session active.
- dv  in  1  data valid.
- l_in  in  1  load/write request.
- test_in  in  TEST_W  compare reference.
- scan_in  in  1  scan chain input.
- scan_en  in  1  scan shift enable.
- fz_L  out  1  freeze, combinational from state.
- lclk  out  1  registered local clock enable.
- read_a  out  ADDR_W  registered counter.
- test_out  out  TEST_W  registered test counter.
- state_o  out  3  current state code.
- conflict  out  1  combinational conflict flag.
- scan_out  out  1  registered scan chain output.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, named clock and reset.

Function
REQ-004 State codes SHALL be IDLE=0, LZ=1, WR=2, SS=3, SD=4, STZ=5, WE=6; code 7 is invalid.
REQ-005 Transitions SHALL be:
- IDLE: s&!dv -> WE, else IDLE.
- WE: !s -> IDLE; dv -> LZ; else WE.
- LZ and WR: !s -> IDLE; l_in -> WR; else SS.
- SS: !s|conflict -> IDLE; else SD.
- SD: !s|conflict -> IDLE; read_a==0 -> STZ; else SD.
- STZ: !s|conflict -> IDLE; read_a==TERM_VAL -> SS; else STZ.
- Invalid code 7 -> IDLE.
REQ-006 fz_L SHALL be 1 only in SD.
REQ-007 In IDLE, WE, LZ and WR ("clear"), the next read_a SHALL be LOAD_VAL and the next lclk SHALL be 0.
REQ-008 In SS, SD, STZ and code 7 ("count"), read_a SHALL decrement by 1 modulo 2^ADDR_W (0 wraps to all-ones).
REQ-009 In a count state, lclk SHALL invert when read_a==TERM_VAL and hold otherwise.
REQ-010 In LZ and WR, test_out SHALL load (test_in+2) mod 2^TEST_W; in all other states it SHALL increment mod 2^TEST_W.
REQ-011 comp SHALL be (test_out==test_in).
REQ-012 comp SHALL shift each cycle into a CONF_DEPTH-bit history register; conflict SHALL be 1 iff all history bits are 1.
REQ-013 state_o SHALL equal the current state register.

Reset
REQ-014 With reset=1 at a clock edge, reset SHALL override scan_en and give state IDLE, read_a=0, lclk=0, test_out=0, history=0, scan_out=0.
REQ-015 After reset, outputs SHALL be fz_L=0 and conflict=0.
REQ-016 Reset asserted mid-operation (any state, any scan position) SHALL take effect at the next edge with no residual state.

Configuration
REQ-017 Macro CUT_GEN_SCAN_CHAIN_EN defined: while scan_en=1 and reset=0, all functional updates SHALL freeze and the registers SHALL form one shift chain.
- Chain order: scan_in -> state[0..2] -> read_a[0..ADDR_W-1] -> lclk -> test_out[0..TEST_W-1] -> history[0..CONF_DEPTH-1] -> scan_out.
- Length is 5+ADDR_W+TEST_W+CONF_DEPTH (14 at defaults).
- scan_out SHALL hold its value while scan_en=0.
REQ-018 Macro undefined: scan_en and scan_in SHALL be ignored, scan_out SHALL be constant 0, and the ports SHALL remain present.

Verification
REQ-019 Defaults; reset, then s=1, dv=0 -> state 6; dv=1 -> state 1, read_a=24, lclk=0, test_out=test_in+2.
REQ-020 From LZ with l_in=0, s=1, test_in chosen so no conflict -> SS, then SD with fz_L=1.
- read_a counts 23..0 -> STZ; read_a wraps to 31, then counts down to 25 -> SS; lclk=1 from the cycle after read_a==25.
REQ-021 In SD, drive test_in equal to test_out for 2 consecutive cycles -> conflict=1 -> IDLE on the next edge, read_a reloaded to 24.
REQ-022 s dropped in each of WE, LZ, WR, SS, SD, STZ -> IDLE on the next edge.
- Force state code 7 through scan -> IDLE after one functional cycle.
REQ-023 With CUT_GEN_SCAN_CHAIN_EN defined: shift pattern 14'h2A5C in with scan_en=1, then shift 14 more cycles -> the same pattern on scan_out, first-in first-out.
- Without the macro: scan_out stays 0 and the FSM is unaffected by scan_en.
REQ-024 Assert reset during the SD count and during scan shift -> all registers at their reset values on the next edge.

Source files
------------

// File: rtl/cut_gen.sv
// cut_gen -- conflict/unload test-sequence generator.
//
// A seven-state FSM walks a write/load preamble (IDLE, WE, LZ, WR) and then
// a counting loop (SS, SD, STZ). The address down-counter read_a, the local
// clock enable lclk and a small test counter run alongside it. A compare of
// test_out against test_in feeds a match history, and a full run of matches
// raises conflict and aborts the loop.
//
// Optional build macro: CUT_GEN_SCAN_CHAIN_EN
//   When defined, scan_en=1 (with reset=0) freezes all functional updates
//   and links every register into one shift chain:
//     scan_in -> state[0..2] -> read_a[0..] -> lclk -> test_out[0..]
//             -> history[0..] -> scan_out
//   When undefined, scan_in/scan_en are ignored and scan_out is tied to 0.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   s, dv, l_in         session active, data valid, load/write request
//   test_in             compare reference for test_out
//   scan_in, scan_en    scan chain input and shift enable
//   fz_L                freeze, high only in SD (decoded from state)
//   lclk                registered local clock enable
//   read_a              registered address down-counter
//   test_out            registered test counter
//   state_o             current state code
//   conflict            all history bits set (decoded from history)
//   scan_out            registered scan chain output
module cut_gen #(
  parameter int ADDR_W     = 5,
  parameter int TEST_W     = 2,
  parameter int LOAD_VAL   = 24,
  parameter int TERM_VAL   = 25,
  parameter int CONF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s,
  input  logic              dv,
  input  logic              l_in,
  input  logic [TEST_W-1:0] test_in,
  input  logic              scan_in,
  input  logic              scan_en,
  output logic              fz_L,
  output logic              lclk,
  output logic [ADDR_W-1:0] read_a,
  output logic [TEST_W-1:0] test_out,
  output logic [2:0]        state_o,
  output logic              conflict,
  output logic              scan_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LZ   = 3'd1,
    WR   = 3'd2,
    SS   = 3'd3,
    SD   = 3'd4,
    STZ  = 3'd5,
    WE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LOAD_A = ADDR_W'(LOAD_VAL);
  localparam logic [ADDR_W-1:0] TERM_A = ADDR_W'(TERM_VAL);

  state_t                state;
  logic [CONF_DEPTH-1:0] hist;
  logic                  comp;
  logic                  clear;
  logic                  load_test;
  // history shifted left with the new compare in bit 0; the extra top bit
  // lets this work unchanged for CONF_DEPTH == 1
  logic [CONF_DEPTH:0]   hist_sh;

  assign comp      = (test_out == test_in);
  assign hist_sh   = {hist, comp};
  assign conflict  = &hist;
  assign fz_L      = (state == SD);
  assign state_o   = state;
  // clear states reload the counter; everything else (including the
  // invalid code 7) counts down
  assign clear     = (state == IDLE) || (state == WE) || (state == LZ) || (state == WR);
  assign load_test = (state == LZ) || (state == WR);

`ifdef CUT_GEN_SCAN_CHAIN_EN
  localparam int CHAIN_W = 4 + ADDR_W + TEST_W + CONF_DEPTH;

  logic [CHAIN_W-1:0] chain;
  logic [CHAIN_W-1:0] chain_sh;
  logic               scan_q;

  // bit 0 of chain is state[0], the cell nearest scan_in
  assign chain    = {hist, test_out, lclk, read_a, state};
  assign chain_sh = {chain[CHAIN_W-2:0], scan_in};
  assign scan_out = scan_q;
`else
  logic unused_scan;
  assign unused_scan = ^{scan_en, scan_in};
  assign scan_out    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      read_a   <= '0;
      lclk     <= 1'b0;
      test_out <= '0;
      hist     <= '0;
`ifdef CUT_GEN_SCAN_CHAIN_EN
      scan_q   <= 1'b0;
`endif
    end
`ifdef CUT_GEN_SCAN_CHAIN_EN
    else if (scan_en) begin
      state    <= state_t'(chain_sh[2:0]);
      read_a   <= chain_sh[3 +: ADDR_W];
      lclk     <= chain_sh[3 + ADDR_W];
      test_out <= chain_sh[4 + ADDR_W +: TEST_W];
      hist     <= chain_sh[4 + ADDR_W + TEST_W +: CONF_DEPTH];
      scan_q   <= chain[CHAIN_W-1];
    end
`endif
    else begin
      case (state)
        IDLE:    if (s && !dv) state <= WE;
        WE: begin
          if (!s)      state <= IDLE;
          else if (dv) state <= LZ;
        end
        LZ, WR: begin
          if (!s)        state <= IDLE;
          else if (l_in) state <= WR;
          else           state <= SS;
        end
        SS: begin
          if (!s || conflict) state <= IDLE;
          else                state <= SD;
        end
        SD: begin
          if (!s || conflict)   state <= IDLE;
          else if (read_a == '0) state <= STZ;
        end
        STZ: begin
          if (!s || conflict)      state <= IDLE;
          else if (read_a == TERM_A) state <= SS;
        end
        default: state <= IDLE;
      endcase

      if (clear) begin
        read_a <= LOAD_A;
        lclk   <= 1'b0;
      end else begin
        read_a <= read_a - ADDR_W'(1);
        if (read_a == TERM_A) lclk <= ~lclk;
      end

      if (load_test) test_out <= test_in + TEST_W'(2);
      else           test_out <= test_out + TEST_W'(1);

      hist <= hist_sh[CONF_DEPTH-1:0];
    end
  end

endmodule
